// File: rtl/axi_wr_arb_pkg.sv
// Shared types and helpers for the two-requester AXI write arbiter.
package axi_wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef logic req_idx_t;

  localparam int DEF_ID_WIDTH = 4;

  // The master ID carries one extra MSB holding the requester index.
  function automatic int m_id_width(input int id_w);
    return id_w + 1;
  endfunction

  localparam int M_ID_WIDTH = m_id_width(DEF_ID_WIDTH);

  // Outstanding-burst counter update; a stray B at zero saturates rather than wrapping.
  function automatic logic [3:0] next_outstanding(input logic [3:0] cnt,
                                                  input logic       inc,
                                                  input logic       dec);
    logic [3:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = cnt + 4'd1;
      2'b01:   nxt = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr.sv
// Registered two-way round-robin pick; the chosen index holds until the next enabled pick.
module axi_rr_arb2
  import axi_wr_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       enable,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  req_idx_t pick_s;

  // Lone requester wins outright; a tie goes to the requester rr_ptr names.
  always_comb begin
    pick_s = 1'b0;
    case (req)
      2'b01:   pick_s = 1'b0;
      2'b10:   pick_s = 1'b1;
      2'b11:   pick_s = rr_ptr;
      default: pick_s = 1'b0;
    endcase
  end

  // Grant register: updated only while the owner is arbitrating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx   <= 1'b0;
      gnt_valid <= 1'b0;
    end else if (enable) begin
      gnt_valid <= |req;
      gnt_idx   <= (|req) ? pick_s : gnt_idx;
    end else begin
      gnt_valid <= gnt_valid;
      gnt_idx   <= gnt_idx;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI4 write master (AW/W/B) between two requesters, whole bursts at a time,
// tagging AWID with the requester index and routing B back by that tag.
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   s0_awaddr,
  input  logic [7:0]                  s0_awlen,
  input  logic [AXI_ID_WIDTH-1:0]     s0_awid,
  input  logic                        s0_awvalid,
  output logic                        s0_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s0_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s0_wstrb,
  input  logic                        s0_wlast,
  input  logic                        s0_wvalid,
  output logic                        s0_wready,
  output logic [AXI_ID_WIDTH-1:0]     s0_bid,
  output logic [1:0]                  s0_bresp,
  output logic                        s0_bvalid,
  input  logic                        s0_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s1_awaddr,
  input  logic [7:0]                  s1_awlen,
  input  logic [AXI_ID_WIDTH-1:0]     s1_awid,
  input  logic                        s1_awvalid,
  output logic                        s1_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s1_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s1_wstrb,
  input  logic                        s1_wlast,
  input  logic                        s1_wvalid,
  output logic                        s1_wready,
  output logic [AXI_ID_WIDTH-1:0]     s1_bid,
  output logic [1:0]                  s1_bresp,
  output logic                        s1_bvalid,
  input  logic                        s1_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [AXI_ID_WIDTH:0]       m_awid,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [AXI_ID_WIDTH:0]       m_bid,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready
);

  localparam int         M_IDW   = m_id_width(AXI_ID_WIDTH);
  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  arb_state_e       state_r;
  req_idx_t         rr_ptr_r;
  logic [3:0]       out_cnt_r;
  req_idx_t         grant_s;
  logic             gnt_valid_s;
  logic [1:0]       req_s;
  logic             full_s;
  logic             arb_en_s;
  logic             arb_fire_s;
  logic             in_addr_s;
  logic             in_data_s;
  logic             sel_awvalid_s;
  logic             sel_wvalid_s;
  logic [M_IDW-1:0] tagged_id_s;
  logic             aw_hs_s;
  logic             w_last_hs_s;
  logic             b_sel_s;
  logic             b_hs_s;

  assign req_s      = {s1_awvalid, s0_awvalid};
  assign full_s     = (out_cnt_r == MAX_OUT);
  assign arb_en_s   = (state_r == IDLE) && !full_s;
  assign arb_fire_s = arb_en_s && (|req_s);
  assign in_addr_s  = (state_r == ADDR) && gnt_valid_s;
  assign in_data_s  = (state_r == DATA) && gnt_valid_s;

  axi_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_s),
    .rr_ptr    (rr_ptr_r),
    .enable    (arb_en_s),
    .gnt_idx   (grant_s),
    .gnt_valid (gnt_valid_s)
  );

  // AW mux: payload always follows the grant, handshake only while in ADDR.
  always_comb begin
    m_awaddr      = grant_s ? s1_awaddr : s0_awaddr;
    m_awlen       = grant_s ? s1_awlen  : s0_awlen;
    tagged_id_s   = {grant_s, (grant_s ? s1_awid : s0_awid)};
    m_awid        = tagged_id_s;
    sel_awvalid_s = grant_s ? s1_awvalid : s0_awvalid;
    m_awvalid     = in_addr_s && sel_awvalid_s;
    s0_awready    = in_addr_s && !grant_s && m_awready;
    s1_awready    = in_addr_s &&  grant_s && m_awready;
    aw_hs_s       = m_awvalid && m_awready;
  end

  // W mux: the channel stays locked to the granted requester until its wlast beat.
  always_comb begin
    m_wdata      = grant_s ? s1_wdata : s0_wdata;
    m_wstrb      = grant_s ? s1_wstrb : s0_wstrb;
    m_wlast      = grant_s ? s1_wlast : s0_wlast;
    sel_wvalid_s = grant_s ? s1_wvalid : s0_wvalid;
    m_wvalid     = in_data_s && sel_wvalid_s;
    s0_wready    = in_data_s && !grant_s && m_wready;
    s1_wready    = in_data_s &&  grant_s && m_wready;
    w_last_hs_s  = m_wvalid && m_wready && m_wlast;
  end

  // B routing by the ID tag bit, independent of the burst FSM.
  always_comb begin
    b_sel_s   = m_bid[AXI_ID_WIDTH];
    s0_bvalid = m_bvalid && !b_sel_s;
    s1_bvalid = m_bvalid &&  b_sel_s;
    s0_bid    = m_bid[AXI_ID_WIDTH-1:0];
    s1_bid    = m_bid[AXI_ID_WIDTH-1:0];
    s0_bresp  = m_bresp;
    s1_bresp  = m_bresp;
    m_bready  = b_sel_s ? s1_bready : s0_bready;
    b_hs_s    = m_bvalid && m_bready;
  end

  // Burst sequencing: arbitrate, forward one AW, then own W until wlast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rr_ptr_r <= rr_ptr_r;
          state_r  <= arb_fire_s ? ADDR : IDLE;
        end
        ADDR: begin
          rr_ptr_r <= rr_ptr_r;
          state_r  <= aw_hs_s ? DATA : ADDR;
        end
        DATA: begin
          if (w_last_hs_s) begin
            rr_ptr_r <= ~grant_s;
            state_r  <= IDLE;
          end else begin
            rr_ptr_r <= rr_ptr_r;
            state_r  <= DATA;
          end
        end
        default: begin
          rr_ptr_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  // Bursts accepted on AW but not yet answered on B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_r <= 4'd0;
    end else begin
      out_cnt_r <= next_outstanding(out_cnt_r, aw_hs_s, b_hs_s);
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: single burst, contention, W lock, outstanding limit, reset.
module tb_axi_wr_arbiter;
  import axi_wr_arb_pkg::*;

  logic                  clk, rst_n;
  logic [31:0]           s0_awaddr, s1_awaddr, m_awaddr;
  logic [7:0]            s0_awlen, s1_awlen, m_awlen;
  logic [3:0]            s0_awid, s1_awid, s0_bid, s1_bid;
  logic                  s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [63:0]           s0_wdata, s1_wdata, m_wdata;
  logic [7:0]            s0_wstrb, s1_wstrb, m_wstrb;
  logic                  s0_wlast, s1_wlast, m_wlast;
  logic                  s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic [1:0]            s0_bresp, s1_bresp, m_bresp;
  logic                  s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic [M_ID_WIDTH-1:0] m_awid, m_bid;
  logic                  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;

  int vectors     = 0;
  int miscompares = 0;

  axi_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awid(s0_awid),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
    .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awid(s1_awid),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // One single-beat burst from a lone requester, starting and ending in IDLE.
  task automatic burst1(input logic idx, input logic [3:0] id, input logic [63:0] d);
    if (idx) begin
      s1_awvalid = 1'b1; s1_awid = id; s1_awlen = 8'd0;
    end else begin
      s0_awvalid = 1'b1; s0_awid = id; s0_awlen = 8'd0;
    end
    cyc();
    settle();
    chk("burst_awid", 64'(m_awid), 64'({idx, id}));
    cyc();
    if (idx) begin
      s1_awvalid = 1'b0; s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = d;
    end else begin
      s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = d;
    end
    settle();
    chk("burst_wdata", m_wdata, d);
    cyc();
    s0_wvalid = 1'b0; s0_wlast = 1'b0;
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
  endtask

  // Protocol watch: no B with nothing outstanding, no awvalid drop while granted in ADDR.
  always @(negedge clk) begin
    if (rst_n && m_bvalid && m_bready) begin
      assert (dut.out_cnt_r != 4'd0) else begin
        miscompares++;
        $error("FAIL b_underflow observed=0 expected=nonzero");
      end
    end
    if (rst_n && (dut.state_r == ADDR)) begin
      assert (m_awvalid) else begin
        miscompares++;
        $error("FAIL awvalid_drop observed=0 expected=1");
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    s0_awaddr = 32'h0; s0_awlen = 8'd0; s0_awid = 4'd0; s0_awvalid = 1'b0;
    s1_awaddr = 32'h0; s1_awlen = 8'd0; s1_awid = 4'd0; s1_awvalid = 1'b0;
    s0_wdata = 64'h0; s0_wstrb = 8'hFF; s0_wlast = 1'b0; s0_wvalid = 1'b0;
    s1_wdata = 64'h0; s1_wstrb = 8'h0F; s1_wlast = 1'b0; s1_wvalid = 1'b0;
    s0_bready = 1'b1; s1_bready = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1;
    m_bid = 5'h00; m_bresp = 2'b00; m_bvalid = 1'b0;

    // Reset state
    cyc();
    settle();
    chk("rst_state", 64'(dut.state_r), 64'(IDLE));
    chk("rst_cnt", 64'(dut.out_cnt_r), 64'd0);
    chk("rst_rr", 64'(dut.rr_ptr_r), 64'd0);
    chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_m_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_s0_awready", 64'(s0_awready), 64'd0);
    chk("rst_s1_wready", 64'(s1_wready), 64'd0);
    cyc();
    rst_n = 1'b1;

    // Single s0 burst, len=3 id=5
    cyc();
    s0_awvalid = 1'b1; s0_awaddr = 32'h0000_1000; s0_awlen = 8'd3; s0_awid = 4'd5;
    settle();
    chk("s0_aw_not_same_cycle", 64'(m_awvalid), 64'd0);
    cyc();
    settle();
    chk("s0_m_awvalid", 64'(m_awvalid), 64'd1);
    chk("s0_m_awid", 64'(m_awid), 64'h05);
    chk("s0_m_awaddr", 64'(m_awaddr), 64'h1000);
    chk("s0_m_awlen", 64'(m_awlen), 64'd3);
    chk("s0_awready", 64'(s0_awready), 64'd1);
    chk("s1_awready_off", 64'(s1_awready), 64'd0);
    cyc();
    s0_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s0_wvalid = 1'b1; s0_wdata = 64'(160 + i); s0_wlast = (i == 3);
      settle();
      chk("s0_beat_data", m_wdata, 64'(160 + i));
      chk("s0_beat_last", 64'(m_wlast), 64'(i == 3));
      chk("s0_beat_ready", 64'(s0_wready), 64'd1);
      cyc();
    end
    s0_wvalid = 1'b0; s0_wlast = 1'b0;
    settle();
    chk("s0_m_wstrb", 64'(m_wstrb), 64'hFF);
    chk("s0_done_state", 64'(dut.state_r), 64'(IDLE));
    chk("s0_done_cnt", 64'(dut.out_cnt_r), 64'd1);
    chk("s0_done_rr", 64'(dut.rr_ptr_r), 64'd1);
    m_bvalid = 1'b1; m_bid = 5'h05; m_bresp = 2'b10;
    settle();
    chk("b0_s0_bvalid", 64'(s0_bvalid), 64'd1);
    chk("b0_s1_bvalid", 64'(s1_bvalid), 64'd0);
    chk("b0_s0_bid", 64'(s0_bid), 64'd5);
    chk("b0_s0_bresp", 64'(s0_bresp), 64'd2);
    chk("b0_m_bready", 64'(m_bready), 64'd1);
    cyc();
    m_bvalid = 1'b0;
    settle();
    chk("b0_cnt", 64'(dut.out_cnt_r), 64'd0);

    // Contention from reset: s0 then s1, twice
    do_reset();
    s0_awvalid = 1'b1; s0_awaddr = 32'h0000_2000; s0_awlen = 8'd0; s0_awid = 4'd1;
    s1_awvalid = 1'b1; s1_awaddr = 32'h0000_3000; s1_awlen = 8'd0; s1_awid = 4'd2;
    cyc();
    settle();
    chk("pair1_first_id", 64'(m_awid), 64'h01);
    chk("pair1_s1_wait", 64'(s1_awready), 64'd0);
    cyc();
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = 64'h11;
    cyc();
    s0_wvalid = 1'b0; s0_wlast = 1'b0;
    settle();
    chk("pair1_idle_gap", 64'(m_awvalid), 64'd0);
    cyc();
    settle();
    chk("pair1_second_id", 64'(m_awid), 64'h12);
    chk("pair1_second_addr", 64'(m_awaddr), 64'h3000);
    chk("pair1_s1_awready", 64'(s1_awready), 64'd1);
    chk("pair1_s0_awready", 64'(s0_awready), 64'd0);
    cyc();
    s1_awvalid = 1'b0; s1_wvalid = 1'b1; s1_wlast = 1'b1; s1_wdata = 64'h22;
    settle();
    chk("pair1_s1_wdata", m_wdata, 64'h22);
    cyc();
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
    s0_awvalid = 1'b1; s0_awid = 4'd3;
    s1_awvalid = 1'b1; s1_awid = 4'd4;
    cyc();
    settle();
    chk("pair2_first_id", 64'(m_awid), 64'h03);
    cyc();
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wlast = 1'b1;
    cyc();
    s0_wvalid = 1'b0; s0_wlast = 1'b0;
    cyc();
    settle();
    chk("pair2_second_id", 64'(m_awid), 64'h14);
    cyc();
    s1_awvalid = 1'b0; s1_wvalid = 1'b1; s1_wlast = 1'b1;
    cyc();
    s1_wvalid = 1'b0; s1_wlast = 1'b0;
    settle();
    chk("pair2_cnt", 64'(dut.out_cnt_r), 64'd4);

    // W lock: s1 W waits while s0 owns the data phase
    do_reset();
    s0_awvalid = 1'b1; s0_awaddr = 32'h0000_4000; s0_awlen = 8'd2; s0_awid = 4'd6;
    s1_wvalid = 1'b1; s1_wdata = 64'h55; s1_wlast = 1'b1;
    settle();
    chk("lock_idle_s1_wready", 64'(s1_wready), 64'd0);
    chk("lock_idle_m_wvalid", 64'(m_wvalid), 64'd0);
    cyc();
    cyc();
    s0_awvalid = 1'b0; s0_wvalid = 1'b1; s0_wdata = 64'hC0; s0_wlast = 1'b0; m_wready = 1'b1;
    settle();
    chk("lock_b0_data", m_wdata, 64'hC0);
    chk("lock_b0_s1_wready", 64'(s1_wready), 64'd0);
    cyc();
    s0_wdata = 64'hC1; m_wready = 1'b0;
    settle();
    chk("lock_b1_stall_data", m_wdata, 64'hC1);
    chk("lock_b1_stall_s0_wready", 64'(s0_wready), 64'd0);
    chk("lock_b1_stall_s1_wready", 64'(s1_wready), 64'd0);
    cyc();
    m_wready = 1'b1;
    settle();
    chk("lock_b1_data", m_wdata, 64'hC1);
    chk("lock_b1_s0_wready", 64'(s0_wready), 64'd1);
    cyc();
    s0_wdata = 64'hC2; s0_wlast = 1'b1;
    settle();
    chk("lock_b2_data", m_wdata, 64'hC2);
    chk("lock_b2_s1_wready", 64'(s1_wready), 64'd0);
    cyc();
    s0_wvalid = 1'b0; s0_wlast = 1'b0;
    settle();
    chk("lock_after_m_wvalid", 64'(m_wvalid), 64'd0);
    chk("lock_after_s1_wready", 64'(s1_wready), 64'd0);
    s1_awvalid = 1'b1; s1_awid = 4'd7; s1_awlen = 8'd0;
    cyc();
    settle();
    chk("lock_s1_aw_id", 64'(m_awid), 64'h17);
    chk("lock_s1_addr_wready", 64'(s1_wready), 64'd0);
    cyc();
    s1_awvalid = 1'b0;
    settle();
    chk("lock_s1_wready", 64'(s1_wready), 64'd1);
    chk("lock_s1_wdata", m_wdata, 64'h55);
    chk("lock_s1_wlast", 64'(m_wlast), 64'd1);
    cyc();
    s1_wvalid = 1'b0; s1_wlast = 1'b0;

    // Outstanding limit and simultaneous AW/B
    do_reset();
    burst1(1'b1, 4'd2, 64'h31);
    burst1(1'b0, 4'd1, 64'h32);
    burst1(1'b1, 4'd3, 64'h33);
    burst1(1'b0, 4'd4, 64'h34);
    settle();
    chk("full_cnt", 64'(dut.out_cnt_r), 64'd4);
    s0_awvalid = 1'b1; s0_awid = 4'd9; s0_awlen = 8'd0;
    cyc();
    cyc();
    cyc();
    settle();
    chk("full_blocked_awvalid", 64'(m_awvalid), 64'd0);
    chk("full_blocked_state", 64'(dut.state_r), 64'(IDLE));
    m_bvalid = 1'b1; m_bid = 5'h12; m_bresp = 2'b01;
    settle();
    chk("full_b_s1_bvalid", 64'(s1_bvalid), 64'd1);
    chk("full_b_s0_bvalid", 64'(s0_bvalid), 64'd0);
    chk("full_b_s1_bid", 64'(s1_bid), 64'd2);
    chk("full_b_s1_bresp", 64'(s1_bresp), 64'd1);
    cyc();
    m_bvalid = 1'b0;
    settle();
    chk("full_b_cnt", 64'(dut.out_cnt_r), 64'd3);
    chk("full_b_arb_gap", 64'(m_awvalid), 64'd0);
    cyc();
    settle();
    chk("fifth_awvalid", 64'(m_awvalid), 64'd1);
    chk("fifth_awid", 64'(m_awid), 64'h09);
    m_awready = 1'b0; m_bvalid = 1'b1; m_bid = 5'h01;
    cyc();
    settle();
    chk("stall_b_cnt", 64'(dut.out_cnt_r), 64'd2);
    m_awready = 1'b1; m_bid = 5'h13;
    cyc();
    m_bvalid = 1'b0; s0_awvalid = 1'b0;
    settle();
    chk("aw_b_same_cnt", 64'(dut.out_cnt_r), 64'd2);
    chk("aw_b_same_state", 64'(dut.state_r), 64'(DATA));
    s0_wvalid = 1'b1; s0_wlast = 1'b1; s0_wdata = 64'h35;
    cyc();
    s0_wvalid = 1'b0; s0_wlast = 1'b0;

    // Reset during beat 2 of a 4-beat s1 burst
    do_reset();
    burst1(1'b0, 4'd5, 64'h41);
    s0_awvalid = 1'b1; s0_awid = 4'd6; s0_awlen = 8'd0;
    s1_awvalid = 1'b1; s1_awid = 4'd7; s1_awlen = 8'd3;
    cyc();
    settle();
    chk("rstmid_grant_s1", 64'(m_awid), 64'h17);
    chk("rstmid_s0_awready", 64'(s0_awready), 64'd0);
    cyc();
    s1_awvalid = 1'b0; s1_wvalid = 1'b1; s1_wdata = 64'hB0; s1_wlast = 1'b0;
    cyc();
    s1_wdata = 64'hB1;
    settle();
    chk("rstmid_beat2", m_wdata, 64'hB1);
    rst_n = 1'b0;
    settle();
    chk("rstmid_m_wvalid", 64'(m_wvalid), 64'd0);
    chk("rstmid_s1_wready", 64'(s1_wready), 64'd0);
    chk("rstmid_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rstmid_s0_awready", 64'(s0_awready), 64'd0);
    chk("rstmid_state", 64'(dut.state_r), 64'(IDLE));
    chk("rstmid_cnt", 64'(dut.out_cnt_r), 64'd0);
    chk("rstmid_rr", 64'(dut.rr_ptr_r), 64'd0);
    s1_wvalid = 1'b0; s1_awvalid = 1'b1;
    cyc();
    rst_n = 1'b1;
    settle();
    chk("post_rst_gap", 64'(m_awvalid), 64'd0);
    cyc();
    settle();
    chk("post_rst_s0_first", 64'(m_awid), 64'h06);
    chk("post_rst_s0_awready", 64'(s0_awready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
